// File: rtl/redun_mont_sq_ctrl.sv
// Sequencer for the redundant-form Montgomery squaring core: resets and loads
// the core, counts result pulses to T, emits checkpoints and runs a watchdog.

package redun_mont_pkg;
  localparam int unsigned NUM_WRDS = 4;
  localparam int unsigned WRD_BITS = 16;
  typedef logic [NUM_WRDS-1:0][WRD_BITS:0] redun_t;
endpackage

module redun_mont_sq_ctrl
  import redun_mont_pkg::*;
#(
  parameter int unsigned ITER_BITS       = 64,
  parameter int unsigned CKPT_SHIFT      = 20,
  parameter int unsigned TIMEOUT         = 1024,
  parameter int unsigned CORE_RST_CYCLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  redun_t               i_init,
  input  logic [ITER_BITS-1:0] i_iter,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output redun_t               o_result,
  output logic                 o_ckpt_val,
  output redun_t               o_ckpt_dat,
  output logic [ITER_BITS-1:0] o_ckpt_iter,
  output logic                 o_core_rst,
  output logic                 o_core_val,
  output redun_t               o_core_sq,
  input  logic                 i_core_val,
  input  redun_t               i_core_mul
);

  localparam int unsigned RCW = (CORE_RST_CYCLES > 1) ? $clog2(CORE_RST_CYCLES) : 1;
  localparam int unsigned WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CRST, S_LOAD, S_RUN, S_DONE} state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  redun_t               result_q, result_d;
  logic                 ckpt_val_q, ckpt_val_d;
  redun_t               ckpt_dat_q, ckpt_dat_d;
  logic [ITER_BITS-1:0] ckpt_iter_q, ckpt_iter_d;
  logic                 core_rst_q, core_rst_d;
  logic                 core_val_q, core_val_d;
  redun_t               init_q, init_d;
  logic [ITER_BITS-1:0] iter_q, iter_d;
  logic [ITER_BITS-1:0] cnt_q, cnt_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [ITER_BITS:0]   cnt_inc;

  // One extra bit so T = 2^ITER_BITS-1 compares without wrapping
  assign cnt_inc = {1'b0, cnt_q} + (ITER_BITS+1)'(1);

  // State and output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      ckpt_val_q  <= 1'b0;
      ckpt_dat_q  <= '0;
      ckpt_iter_q <= '0;
      core_rst_q  <= 1'b1;
      core_val_q  <= 1'b0;
      init_q      <= '0;
      iter_q      <= '0;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      result_q    <= result_d;
      ckpt_val_q  <= ckpt_val_d;
      ckpt_dat_q  <= ckpt_dat_d;
      ckpt_iter_q <= ckpt_iter_d;
      core_rst_q  <= core_rst_d;
      core_val_q  <= core_val_d;
      init_q      <= init_d;
      iter_q      <= iter_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      wd_q        <= wd_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    result_d    = result_q;
    ckpt_val_d  = 1'b0;
    ckpt_dat_d  = ckpt_dat_q;
    ckpt_iter_d = ckpt_iter_q;
    init_d      = init_q;
    iter_d      = iter_q;
    cnt_d       = cnt_q;
    rst_cnt_d   = rst_cnt_q;
    wd_d        = wd_q;

    case (state_q)
      S_IDLE: begin
        if (done_q) begin
          busy_d = 1'b0;
        end else if (i_start && !i_abort && !busy_q) begin
          init_d    = i_init;
          iter_d    = i_iter;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          cnt_d     = '0;
          rst_cnt_d = '0;
          if (i_iter == '0) begin
            result_d = i_init;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CRST;
          end
        end
      end
      S_CRST: begin
        if (i_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (rst_cnt_q == RCW'(CORE_RST_CYCLES - 1)) begin
          state_d = S_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_LOAD: begin
        if (i_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RUN;
          cnt_d   = '0;
          wd_d    = '0;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (i_core_val) begin
          cnt_d = cnt_inc[ITER_BITS-1:0];
          wd_d  = '0;
          if (cnt_inc == {1'b0, iter_q}) begin
            result_d = i_core_mul;
            state_d  = S_DONE;
          end else if (cnt_inc[CKPT_SHIFT-1:0] == '0) begin
            ckpt_val_d  = 1'b1;
            ckpt_dat_d  = i_core_mul;
            ckpt_iter_d = cnt_inc[ITER_BITS-1:0];
          end
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core interface follows the state being entered so it lines up with it
    core_rst_d = !((state_d == S_LOAD) || (state_d == S_RUN));
    core_val_d = (state_d == S_LOAD);
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_result    = result_q;
  assign o_ckpt_val  = ckpt_val_q;
  assign o_ckpt_dat  = ckpt_dat_q;
  assign o_ckpt_iter = ckpt_iter_q;
  assign o_core_rst  = core_rst_q;
  assign o_core_val  = core_val_q;
  assign o_core_sq   = init_q;

endmodule

// File: tb/tb_redun_mont_sq_ctrl.sv
// Bench for redun_mont_sq_ctrl: random core model plus directed scenarios.

module tb_redun_mont_sq_ctrl;
  import redun_mont_pkg::*;

  localparam int unsigned IB  = 64;
  localparam int unsigned CS  = 2;
  localparam int unsigned TO  = 16;
  localparam int unsigned CRC = 4;
  localparam int unsigned CKP = 1 << CS;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          i_start = 1'b0;
  redun_t        i_init = '0;
  logic [IB-1:0] i_iter = '0;
  logic          i_abort = 1'b0;
  logic          o_busy, o_done, o_err, o_ckpt_val, o_core_rst, o_core_val;
  redun_t        o_result, o_ckpt_dat, o_core_sq;
  logic [IB-1:0] o_ckpt_iter;
  logic          i_core_val = 1'b0;
  redun_t        i_core_mul = '0;

  redun_mont_sq_ctrl #(.ITER_BITS(IB), .CKPT_SHIFT(CS), .TIMEOUT(TO), .CORE_RST_CYCLES(CRC)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_init(i_init), .i_iter(i_iter),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_result(o_result),
    .o_ckpt_val(o_ckpt_val), .o_ckpt_dat(o_ckpt_dat), .o_ckpt_iter(o_ckpt_iter),
    .o_core_rst(o_core_rst), .o_core_val(o_core_val), .o_core_sq(o_core_sq),
    .i_core_val(i_core_val), .i_core_mul(i_core_mul));

  initial forever #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic redun_t rand_val();
    redun_t v;
    for (int i = 0; i < NUM_WRDS; i++) v[i] = (WRD_BITS+1)'($urandom);
    return v;
  endfunction

  // Core model: after each load strobe, one result every lat cycles, up to stall_lim
  int unsigned lat = 1;
  int unsigned stall_lim = 1000;
  redun_t      hist[$];
  initial begin : core_model
    bit armed;
    int unsigned cd, produced;
    redun_t v;
    armed = 1'b0; cd = 0; produced = 0;
    forever begin
      @(posedge i_clk);
      #1;
      i_core_val = 1'b0;
      if (o_core_rst === 1'b1) armed = 1'b0;
      if (o_core_val === 1'b1) begin
        armed = 1'b1; cd = lat; produced = 0; hist.delete();
      end else if (armed) begin
        cd--;
        if (cd == 0) begin
          if (produced < stall_lim) begin
            v = rand_val();
            i_core_val = 1'b1;
            i_core_mul = v;
            hist.push_back(v);
            produced++;
          end
          cd = lat;
        end
      end
    end
  end

  // Output monitor
  int unsigned   done_cnt = 0, done_cyc = 0, load_cnt = 0, pulse_cyc = 0, err_cyc = 0, ck_n = 0;
  redun_t        done_val = '0;
  logic          err_prev = 1'b0;
  logic [IB-1:0] ck_iter_a [0:63];
  redun_t        ck_dat_a  [0:63];
  always @(negedge i_clk) begin
    if (o_done === 1'b1) begin
      done_cnt <= done_cnt + 1; done_cyc <= cyc; done_val <= o_result;
    end
    if (o_ckpt_val === 1'b1 && ck_n < 64) begin
      ck_iter_a[ck_n] <= o_ckpt_iter; ck_dat_a[ck_n] <= o_ckpt_dat; ck_n <= ck_n + 1;
    end
    if (o_core_val === 1'b1) load_cnt <= load_cnt + 1;
    if (i_core_val) pulse_cyc <= cyc;
    if (o_err === 1'b1 && err_prev !== 1'b1) err_cyc <= cyc;
    err_prev <= o_err;
  end

  int unsigned s_cyc = 0;

  task automatic start_run(input logic [IB-1:0] t, input redun_t init);
    @(posedge i_clk); #1;
    i_start = 1'b1; i_init = init; i_iter = t; s_cyc = cyc;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned base, input int unsigned budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != base) break;
      @(negedge i_clk); #1;
    end
    chk({tag, "_done"}, 128'(done_cnt), 128'(base + 1));
  endtask

  // Full run compared against the reference: T-th core output, checkpoints, latency
  task automatic do_run(input int unsigned t, input int unsigned l, input redun_t init, input string tag);
    int unsigned ck0, ld0, dn0, nexp, ngot;
    redun_t exp_res;
    lat = l; stall_lim = 1000;
    ck0 = ck_n; ld0 = load_cnt; dn0 = done_cnt;
    start_run(IB'(t), init);
    chk({tag, "_busy_hi"}, 128'(o_busy), 128'(1));
    wait_done(dn0, 600, tag);
    exp_res = (t == 0) ? init : hist[t-1];
    chk({tag, "_result"}, 128'(done_val), 128'(exp_res));
    chk({tag, "_latency"}, 128'(done_cyc - s_cyc),
        128'((t == 0) ? 2 : (1 + CRC + 1 + l * t + 1)));
    chk({tag, "_loads"}, 128'(load_cnt - ld0), 128'((t == 0) ? 0 : 1));
    nexp = (t == 0) ? 0 : (t - 1) / CKP;
    ngot = ck_n - ck0;
    chk({tag, "_nckpt"}, 128'(ngot), 128'(nexp));
    for (int k = 0; k < nexp && k < ngot; k++) begin
      chk({tag, "_ckpt_iter"}, 128'(ck_iter_a[ck0+k]), 128'((k + 1) * CKP));
      chk({tag, "_ckpt_dat"}, 128'(ck_dat_a[ck0+k]), 128'(hist[(k + 1) * CKP - 1]));
    end
    chk({tag, "_core_rst"}, 128'(o_core_rst), 128'(1));
    @(negedge i_clk); #1;
    chk({tag, "_busy_lo"}, 128'(o_busy), 128'(0));
    chk({tag, "_done_lo"}, 128'(o_done), 128'(0));
  endtask

  initial begin : main
    redun_t init3, prev_res;
    int unsigned dn0, ck0;
    bit found;

    // Reset state
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_core_rst", 128'(o_core_rst), 128'(1));
    chk("rst_busy", 128'(o_busy), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    chk("rst_result", 128'(o_result), 128'(0));
    chk("rst_ckpt", 128'(o_ckpt_val), 128'(0));
    chk("rst_core_val", 128'(o_core_val), 128'(0));
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // T=1 with init 3, then T=0, then T=10 with checkpoints at 4 and 8
    init3 = '0; init3[0] = 17'd3;
    do_run(1, 2, init3, "t1");
    do_run(0, 1, rand_val(), "t0");
    do_run(10, 1, rand_val(), "t10");
    chk("t10_ck4", 128'(ck_iter_a[ck_n-2]), 128'(4));
    chk("t10_ck8", 128'(ck_iter_a[ck_n-1]), 128'(8));

    // Random runs
    for (int r = 0; r < 6; r++)
      do_run($urandom_range(20, 1), $urandom_range(3, 1), rand_val(), "rnd");

    // Start together with abort is ignored
    @(posedge i_clk); #1;
    i_start = 1'b1; i_abort = 1'b1; i_iter = IB'(5);
    @(posedge i_clk); #1;
    i_start = 1'b0; i_abort = 1'b0;
    chk("start_abort_busy", 128'(o_busy), 128'(0));

    // Watchdog: core stalls after 3 results
    dn0 = done_cnt;
    lat = 2; stall_lim = 3;
    start_run(IB'(10), rand_val());
    for (int i = 0; i < 200; i++) begin
      if (o_err === 1'b1) break;
      @(negedge i_clk); #1;
    end
    chk("wd_err", 128'(o_err), 128'(1));
    chk("wd_hist", 128'(hist.size()), 128'(3));
    chk("wd_timing", 128'(err_cyc - (pulse_cyc + 1)), 128'(TO));
    chk("wd_busy", 128'(o_busy), 128'(0));
    chk("wd_core_rst", 128'(o_core_rst), 128'(1));
    repeat (5) @(negedge i_clk); #1;
    chk("wd_no_done", 128'(done_cnt), 128'(dn0));
    do_run(1, 1, rand_val(), "wd_next");
    chk("wd_err_clr", 128'(o_err), 128'(0));

    // Abort in RUN on the same cycle as a core result
    prev_res = o_result;
    dn0 = done_cnt;
    lat = 2; stall_lim = 1000; found = 1'b0;
    start_run(IB'(20), rand_val());
    for (int i = 0; i < 300; i++) begin
      @(posedge i_clk); #2;
      if (hist.size() >= 3 && i_core_val) begin found = 1'b1; break; end
    end
    chk("ab_sync", 128'(found), 128'(1));
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;
    @(negedge i_clk); #1;
    chk("ab_busy", 128'(o_busy), 128'(0));
    chk("ab_core_rst", 128'(o_core_rst), 128'(1));
    repeat (10) @(negedge i_clk); #1;
    chk("ab_no_done", 128'(done_cnt), 128'(dn0));
    chk("ab_result", 128'(o_result), 128'(prev_res));
    chk("ab_err", 128'(o_err), 128'(0));
    do_run(2, 1, rand_val(), "ab_next");

    // Maximum T: no premature completion, checkpoint at 4 still issued
    dn0 = done_cnt; ck0 = ck_n;
    lat = 1; stall_lim = 1000;
    start_run('1, rand_val());
    for (int i = 0; i < 100; i++) begin
      if (hist.size() >= 6) break;
      @(negedge i_clk); #1;
    end
    @(negedge i_clk); #1;
    chk("max_busy", 128'(o_busy), 128'(1));
    chk("max_no_done", 128'(done_cnt), 128'(dn0));
    chk("max_ckpt", 128'(ck_iter_a[ck0]), 128'(4));
    i_abort = 1'b1;
    @(posedge i_clk); #1;
    i_abort = 1'b0;

    // Async reset mid-RUN
    lat = 2;
    start_run(IB'(20), rand_val());
    for (int i = 0; i < 100; i++) begin
      if (hist.size() >= 2) break;
      @(negedge i_clk); #1;
    end
    @(posedge i_clk); #3;
    i_rst_n = 1'b0;
    #1;
    chk("ar_busy", 128'(o_busy), 128'(0));
    chk("ar_core_rst", 128'(o_core_rst), 128'(1));
    chk("ar_result", 128'(o_result), 128'(0));
    chk("ar_ckpt_iter", 128'(o_ckpt_iter), 128'(0));
    chk("ar_core_sq", 128'(o_core_sq), 128'(0));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    do_run(2, 1, rand_val(), "ar_next");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
